// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues one instruction-memory read per
// instruction over a req/valid handshake, and holds the returned word in an
// instruction register until decode consumes it, a branch/jump redirects it,
// or a HALT stops fetching until the next reset.
module instr_fetch #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [4:0]  HALT_OP  = 5'b00000,
    parameter logic [15:0] NOP_WORD = 16'h0800
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic [4:0]  opcode,
    output logic [1:0]  func,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_HALTED
    } state_t;

    state_t      state;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [15:0] ir_pc;
    logic        kill;

    // Fetch sequencing: PC update, kill tracking for in-flight reads, IR capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_REQ;
            pc    <= RESET_PC;
            kill  <= 1'b0;
            ir    <= NOP_WORD;
            ir_pc <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    // Request is already on the bus; a redirect can only
                    // mark its response as stale.
                    state <= S_WAIT;
                    if (redirect) begin
                        pc   <= redirect_pc;
                        kill <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        pc <= redirect_pc;
                        if (imem_valid) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (imem_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= S_REQ;
                        end else begin
                            ir    <= imem_rdata;
                            ir_pc <= pc;
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        pc    <= redirect_pc;
                        state <= S_REQ;
                    end else if (!stall) begin
                        if (ir[15:11] == HALT_OP) begin
                            state <= S_HALTED;
                        end else begin
                            pc    <= pc + 16'd2;
                            state <= S_REQ;
                        end
                    end
                end
                S_HALTED: begin
                end
                default: state <= S_REQ;
            endcase
        end
    end

    // No request may leave the stage while reset is being applied.
    assign imem_req    = (state == S_REQ) && rst_n;
    assign imem_addr   = pc;
    assign instr_valid = (state == S_HOLD);
    assign halted      = (state == S_HALTED);

    assign instr    = ir;
    assign opcode   = ir[15:11];
    assign func     = ir[1:0];
    assign pc_out   = ir_pc;
    assign pc_plus2 = ir_pc + 16'd2;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a cycle table for the streaming and
// stall behaviour, hand-written sequences for redirect, HALT and reset corner
// cases, and a scoreboard fed by the memory model on every accepted response.
module tb_instr_fetch;

    logic clk = 1'b0;

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;

    logic        a_req, a_valid, a_halted;
    logic [15:0] a_addr, a_instr, a_pco, a_pp2;
    logic [4:0]  a_op;
    logic [1:0]  a_func;

    logic        b_req, b_valid, b_halted;
    logic [15:0] b_addr, b_instr, b_pco, b_pp2;
    logic [4:0]  b_op;
    logic [1:0]  b_func;

    instr_fetch dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (a_req),
        .imem_addr   (a_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (a_instr),
        .instr_valid (a_valid),
        .opcode      (a_op),
        .func        (a_func),
        .pc_out      (a_pco),
        .pc_plus2    (a_pp2),
        .halted      (a_halted)
    );

    instr_fetch #(.RESET_PC(16'hFFFE)) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (b_req),
        .imem_addr   (b_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr       (b_instr),
        .instr_valid (b_valid),
        .opcode      (b_op),
        .func        (b_func),
        .pc_out      (b_pco),
        .pc_plus2    (b_pp2),
        .halted      (b_halted)
    );

    // The memory model and all checks follow whichever instance is selected.
    logic        sel;
    logic        v_req, v_valid, v_halted;
    logic [15:0] v_addr, v_instr, v_pco, v_pp2;
    logic [4:0]  v_op;
    logic [1:0]  v_func;

    assign v_req    = sel ? b_req    : a_req;
    assign v_valid  = sel ? b_valid  : a_valid;
    assign v_halted = sel ? b_halted : a_halted;
    assign v_addr   = sel ? b_addr   : a_addr;
    assign v_instr  = sel ? b_instr  : a_instr;
    assign v_pco    = sel ? b_pco    : a_pco;
    assign v_pp2    = sel ? b_pp2    : a_pp2;
    assign v_op     = sel ? b_op     : a_op;
    assign v_func   = sel ? b_func   : a_func;

    typedef struct {
        int          due;
        logic [15:0] addr;
    } pend_t;

    typedef struct {
        logic [15:0] word;
        logic [15:0] pc;
    } sb_t;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        exp_valid;
        logic [15:0] exp_instr;
        logic [15:0] exp_pco;
    } vec_t;

    logic [15:0] mem [logic [15:0]];
    pend_t       pq[$];
    sb_t         sbq[$];
    vec_t        tbl [19];

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc;
    int   lat;
    int   drop_cnt;
    logic prev_valid;

    function automatic logic [15:0] memrd(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return 16'h4000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string t, input logic e_req, input logic [15:0] e_addr,
                             input logic e_valid, input logic e_halted);
        chk($sformatf("%s_req", t),    32'(v_req),    32'(e_req));
        chk($sformatf("%s_addr", t),   32'(v_addr),   32'(e_addr));
        chk($sformatf("%s_valid", t),  32'(v_valid),  32'(e_valid));
        chk($sformatf("%s_halted", t), 32'(v_halted), 32'(e_halted));
    endtask

    task automatic check_ir(input string t, input logic [15:0] e_instr, input logic [15:0] e_pco);
        logic [15:0] w;
        logic [15:0] p2;
        w  = e_instr;
        p2 = e_pco + 16'd2;
        chk($sformatf("%s_instr", t),  32'(v_instr), 32'(w));
        chk($sformatf("%s_opcode", t), 32'(v_op),    32'(w[15:11]));
        chk($sformatf("%s_func", t),   32'(v_func),  32'(w[1:0]));
        chk($sformatf("%s_pc_out", t), 32'(v_pco),   32'(e_pco));
        chk($sformatf("%s_pc_plus2", t), 32'(v_pp2), 32'(p2));
    endtask

    task automatic drive(input logic rn, input logic s, input logic r, input logic [15:0] rpc);
        rst_n       = rn;
        stall       = s;
        redirect    = r;
        redirect_pc = rpc;
        #1;
    endtask

    // Memory model, scoreboard push/pop, then advance one clock.
    task automatic tick();
        pend_t np;
        sb_t   e;
        imem_valid = 1'b0;
        imem_rdata = 16'h0000;
        if (v_req === 1'b1) begin
            np.due  = cyc + lat;
            np.addr = v_addr;
            pq.push_back(np);
        end
        if (pq.size() > 0 && pq[0].due == cyc) begin
            np = pq.pop_front();
            imem_valid = 1'b1;
            imem_rdata = memrd(np.addr);
            if (drop_cnt > 0) begin
                drop_cnt--;
            end else begin
                e.word = imem_rdata;
                e.pc   = np.addr;
                sbq.push_back(e);
            end
        end
        if (v_valid === 1'b1 && !prev_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL c%0d_present: got instr %0h at pc %0h, expected no instruction", cyc, v_instr, v_pco);
            end else begin
                e = sbq.pop_front();
                check_ir($sformatf("c%0d_sb", cyc), e.word, e.pc);
            end
        end
        prev_valid = (v_valid === 1'b1);
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic row(input int i, input logic s, input logic r, input logic [15:0] rpc,
                       input logic er, input logic [15:0] ea, input logic ev,
                       input logic [15:0] ei, input logic [15:0] ep);
        tbl[i].stall     = s;
        tbl[i].redirect  = r;
        tbl[i].rpc       = rpc;
        tbl[i].exp_req   = er;
        tbl[i].exp_addr  = ea;
        tbl[i].exp_valid = ev;
        tbl[i].exp_instr = ei;
        tbl[i].exp_pco   = ep;
    endtask

    // Test sequence.
    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_valid = 1'b0; imem_rdata = 16'h0000;
        sel = 1'b0; lat = 1; drop_cnt = 0; prev_valid = 1'b0; cyc = 0;

        mem[16'h0000] = 16'h4000;
        mem[16'h0002] = 16'h4801;
        mem[16'h0004] = 16'hD803;
        mem[16'h0006] = 16'hD802;
        mem[16'h0008] = 16'h5004;
        mem[16'h0400] = 16'h6802;
        mem[16'hFFFE] = 16'h4001;

        //      i  stall rdr rpc       req addr      vld instr     pc_out
        row( 0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0800, 16'h0000);
        row( 1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0800, 16'h0000);
        row( 2, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h4000, 16'h0000);
        row( 3, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h4000, 16'h0000);
        row( 4, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b0, 16'h4000, 16'h0000);
        row( 5, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h4801, 16'h0002);
        row( 6, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b0, 16'h4801, 16'h0002);
        row( 7, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h4801, 16'h0002);
        row( 8, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 16'hD803, 16'h0004);
        row( 9, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0006, 1'b0, 16'hD803, 16'h0004);
        row(10, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b0, 16'hD803, 16'h0004);
        row(11, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hD802, 16'h0006);
        row(12, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hD802, 16'h0006);
        row(13, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hD802, 16'h0006);
        row(14, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hD802, 16'h0006);
        row(15, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0006, 1'b1, 16'hD802, 16'h0006);
        row(16, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b0, 16'hD802, 16'h0006);
        row(17, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b0, 16'hD802, 16'h0006);
        row(18, 1'b1, 1'b1, 16'h0004, 1'b0, 16'h0008, 1'b1, 16'h5004, 16'h0008);

        // c0: reset held; state already REQ but no request may go out.
        @(negedge clk);
        #1;
        check_out("c0_rst", 1'b0, 16'h0000, 1'b0, 1'b0);
        check_ir("c0_rst", 16'h0800, 16'h0000);
        tick();

        // c1..c19: streaming, 4-cycle stall, then redirect from HOLD under stall.
        for (int i = 0; i < 19; i++) begin
            drive(1'b1, tbl[i].stall, tbl[i].redirect, tbl[i].rpc);
            check_out($sformatf("c%0d", cyc), tbl[i].exp_req, tbl[i].exp_addr,
                      tbl[i].exp_valid, 1'b0);
            check_ir($sformatf("c%0d", cyc), tbl[i].exp_instr, tbl[i].exp_pco);
            tick();
        end

        // Redirect while a 3-cycle read of 0x0004 is pending.
        lat = 3;
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("rd1_req", 1'b1, 16'h0004, 1'b0, 1'b0);
        tick();
        drop_cnt++;
        drive(1'b1, 1'b0, 1'b1, 16'h0100);
        check_out("rd1_wait", 1'b0, 16'h0004, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("rd1_kill%0d", k), 1'b0, 16'h0100, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("rd1_next", 1'b1, 16'h0100, 1'b0, 1'b0);
        check_ir("rd1_next", 16'h5004, 16'h0008);
        tick();

        // Redirect in the same cycle as imem_valid.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("rd2_wait%0d", k), 1'b0, 16'h0100, 1'b0, 1'b0);
            tick();
        end
        drop_cnt++;
        drive(1'b1, 1'b0, 1'b1, 16'h0200);
        check_out("rd2_same", 1'b0, 16'h0100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("rd2_next", 1'b1, 16'h0200, 1'b0, 1'b0);
        tick();

        // Two redirects in one wait: the later target wins.
        drop_cnt++;
        drive(1'b1, 1'b0, 1'b1, 16'h0300);
        check_out("rd3_w0", 1'b0, 16'h0200, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 16'h0400);
        check_out("rd3_w1", 1'b0, 16'h0300, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("rd3_w2", 1'b0, 16'h0400, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("rd3_next", 1'b1, 16'h0400, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("rd3_fetch%0d", k), 1'b0, 16'h0400, 1'b0, 1'b0);
            tick();
        end

        // HOLD of 0x6802, redirect to the HALT word at 0x0006.
        mem[16'h0006] = 16'h0000;
        lat = 1;
        drive(1'b1, 1'b0, 1'b1, 16'h0006);
        check_out("h_hold", 1'b0, 16'h0400, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("h_req", 1'b1, 16'h0006, 1'b0, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("h_wait", 1'b0, 16'h0006, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h0000);
            check_out($sformatf("h_stall%0d", k), 1'b0, 16'h0006, 1'b1, 1'b0);
            check_ir($sformatf("h_stall%0d", k), 16'h0000, 16'h0006);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("h_consume", 1'b0, 16'h0006, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 16'h0100);
        check_out("h_halted", 1'b0, 16'h0006, 1'b0, 1'b1);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("h_after%0d", k), 1'b0, 16'h0006, 1'b0, 1'b1);
            tick();
        end

        // RESET_PC=FFFE instance: reset mid-WAIT at 0x0020, stale response, wrap.
        sel = 1'b1;
        prev_valid = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("b_rst_req", 32'(v_req), 32'(1'b0));
        tick();
        lat = 2;
        drop_cnt++;
        drive(1'b1, 1'b0, 1'b1, 16'h0020);
        check_out("b_req0", 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check_ir("b_req0", 16'h0800, 16'hFFFE);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("b_kill%0d", k), 1'b0, 16'h0020, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("b_req20", 1'b1, 16'h0020, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        check_out("b_rst_wait", 1'b0, 16'h0020, 1'b0, 1'b0);
        tick();
        drop_cnt++;
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("b_after_rst", 1'b1, 16'hFFFE, 1'b0, 1'b0);
        check_ir("b_after_rst", 16'h0800, 16'hFFFE);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            check_out($sformatf("b_wait%0d", k), 1'b0, 16'hFFFE, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("b_hold", 1'b0, 16'hFFFE, 1'b1, 1'b0);
        tick();
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        check_out("b_wrap", 1'b1, 16'h0000, 1'b0, 1'b0);
        check_ir("b_wrap", 16'h4001, 16'hFFFE);

        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("drops_used", 32'(drop_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
